// File: rtl/hazard_stall_ctrl.sv
// Load-use / multiply-occupancy / branch-flush sequencer for the 5-stage DLX pipeline.
// Optional HAZARD_STATS_EN adds saturating StallCycles and FlushCount counters.
module hazard_stall_ctrl #(
    parameter int unsigned MUL_LATENCY = 4,
    parameter logic [5:0]  MUL_FUNC    = 6'h0e,
    parameter logic [5:0]  MULU_FUNC   = 6'h16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:5]  IDRs1,
    input  logic [0:5]  IDRs2,
    input  logic        IDUsesRs2,
    input  logic [0:5]  EXERd,
    input  logic [0:5]  EXEOpCode,
    input  logic [0:5]  EXEFunction,
    input  logic        BranchTaken,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFIDFlush,
    output logic        IDEXEWrite,
    output logic        IDEXEBubble,
    output logic        EXEMEMBubble,
    output logic        MulBusy
`ifdef HAZARD_STATS_EN
    ,
    output logic [0:31] StallCycles,
    output logic [0:15] FlushCount
`endif
);

    typedef enum logic {RUN, MUL_WAIT} state_t;

    // Entry cycle is itself a freeze cycle, so the counter covers the remaining MUL_LATENCY-2.
    localparam bit         MUL_STALL_EN = (MUL_LATENCY > 1);
    localparam logic [3:0] MUL_LOAD     = MUL_STALL_EN ? 4'(MUL_LATENCY - 2) : 4'd0;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_mul_cnt, w_mul_cnt_nxt;
    logic        w_is_load, w_is_mul, w_load_use;

    assign w_is_load  = (EXEOpCode >= 6'h20) && (EXEOpCode <= 6'h25);
    assign w_is_mul   = MUL_STALL_EN && (EXEOpCode == 6'h00) &&
                        ((EXEFunction == MUL_FUNC) || (EXEFunction == MULU_FUNC));
    assign w_load_use = w_is_load && (EXERd != 6'd0) &&
                        ((EXERd == IDRs1) || (IDUsesRs2 && (EXERd == IDRs2)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= RUN;
            r_mul_cnt <= 4'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_mul_cnt <= w_mul_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_mul_cnt_nxt = r_mul_cnt;
        PCWrite       = 1'b1;
        IFIDWrite     = 1'b1;
        IFIDFlush     = 1'b0;
        IDEXEWrite    = 1'b1;
        IDEXEBubble   = 1'b0;
        EXEMEMBubble  = 1'b0;
        MulBusy       = 1'b0;
        if (reset) begin
            w_state_nxt   = RUN;
            w_mul_cnt_nxt = 4'd0;
        end else begin
            case (r_state)
                RUN: begin
                    if (BranchTaken) begin
                        IFIDFlush   = 1'b1;
                        IDEXEBubble = 1'b1;
                    end else if (w_is_mul) begin
                        PCWrite       = 1'b0;
                        IFIDWrite     = 1'b0;
                        IDEXEWrite    = 1'b0;
                        EXEMEMBubble  = 1'b1;
                        MulBusy       = 1'b1;
                        w_mul_cnt_nxt = MUL_LOAD;
                        w_state_nxt   = MUL_WAIT;
                    end else if (w_load_use) begin
                        PCWrite     = 1'b0;
                        IFIDWrite   = 1'b0;
                        IDEXEBubble = 1'b1;
                    end
                end
                MUL_WAIT: begin
                    // EXE is occupied by the multiply, so branch and load-use are not evaluated.
                    if (r_mul_cnt != 4'd0) begin
                        PCWrite       = 1'b0;
                        IFIDWrite     = 1'b0;
                        IDEXEWrite    = 1'b0;
                        EXEMEMBubble  = 1'b1;
                        MulBusy       = 1'b1;
                        w_mul_cnt_nxt = r_mul_cnt - 4'd1;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end
                default: w_state_nxt = RUN;
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            StallCycles <= '0;
            FlushCount  <= '0;
        end else begin
            if (!PCWrite && (StallCycles != '1))
                StallCycles <= StallCycles + 32'd1;
            if (IFIDFlush && (FlushCount != '1))
                FlushCount <= FlushCount + 16'd1;
        end
    end
`endif

endmodule
